// File: rtl/stream_pkg.sv
// rtl/stream_pkg.sv - shared FSM states, count width and saturating adder for stream_group_accum
package stream_pkg;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  localparam int CNT_W     = 8;
  localparam int SAT_MAX_W = 32;

  // Returns {sat, sum}: sum clamps to 2^w-1 when a+b does not fit in w bits (w <= SAT_MAX_W).
  function automatic logic [SAT_MAX_W:0] sat_add(input logic [SAT_MAX_W-1:0] a,
                                                 input logic [SAT_MAX_W-1:0] b,
                                                 input int unsigned          w);
    logic [SAT_MAX_W:0] s;
    logic [SAT_MAX_W:0] lim;
    s   = {1'b0, a} + {1'b0, b};
    lim = (SAT_MAX_W+1)'(1) << w;
    if (s >= lim) sat_add = {1'b1, SAT_MAX_W'(lim - 1'b1)};
    else          sat_add = s;
  endfunction

endpackage

// File: rtl/stream_result_reg.sv
// rtl/stream_result_reg.sv - single-entry valid/ready result holding register
module stream_result_reg
  import stream_pkg::*;
#(
  parameter int SW = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [SW-1:0]    ld_sum,
  input  logic [CNT_W-1:0] ld_cnt,
  input  logic             ld_sat,
  input  logic             out_ready,
  output logic [SW-1:0]    out_sum,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_sat,
  output logic             out_valid
);

  // A load in the same cycle as a consume overwrites the slot and keeps it valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_sum   <= '0;
      out_cnt   <= '0;
      out_sat   <= 1'b0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_sum   <= ld_sum;
      out_cnt   <= ld_cnt;
      out_sat   <= ld_sat;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_group_accum.sv
// rtl/stream_group_accum.sv - sums groups of GROUP stream items into result beats
// Optional flush input enabled by STREAM_GROUP_ACCUM_FLUSH_EN.
module stream_group_accum
  import stream_pkg::*;
#(
  parameter int DW    = 6,
  parameter int SW    = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [SW-1:0]    out_sum,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_sat,
  output logic             out_valid,
  input  logic             out_ready
`ifdef STREAM_GROUP_ACCUM_FLUSH_EN
  ,
  input  logic             flush
`endif
);

  state_t             state_q, state_d;
  logic [SW-1:0]      acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               acc_sat_q;
  logic               accept_in;
  logic [SAT_MAX_W:0] add_r;
  logic [SAT_MAX_W:0] unused_add;
  logic [SW-1:0]      acc_n;
  logic               sat_n;
  logic [CNT_W-1:0]   cnt_inc;
  logic               last_item;
  logic               close_flush;
  logic               load;
  logic [SW-1:0]      ld_sum;
  logic [CNT_W-1:0]   ld_cnt;
  logic               ld_sat;

  assign in_ready  = (state_q == ST_ACCUM) | out_ready;
  assign accept_in = in_valid & in_ready;

  assign add_r      = sat_add(SAT_MAX_W'(acc_q), SAT_MAX_W'(in_data), SW);
  assign unused_add = add_r;
  assign acc_n      = add_r[SW-1:0];
  assign sat_n      = add_r[SAT_MAX_W];
  assign cnt_inc    = cnt_q + 1'b1;
  assign last_item  = accept_in && (cnt_q == CNT_W'(GROUP - 1));

`ifdef STREAM_GROUP_ACCUM_FLUSH_EN
  // Flush is ignored while a result is held; upstream keeps it asserted.
  assign close_flush = flush && (state_q == ST_ACCUM) && ((cnt_q != '0) || accept_in);
`else
  assign close_flush = 1'b0;
`endif

  assign load   = last_item | close_flush;
  assign ld_sum = accept_in ? acc_n : acc_q;
  assign ld_cnt = accept_in ? cnt_inc : cnt_q;
  assign ld_sat = acc_sat_q | (accept_in & sat_n);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      acc_sat_q <= 1'b0;
    end else if (load) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      acc_sat_q <= 1'b0;
    end else if (accept_in) begin
      acc_q     <= acc_n;
      cnt_q     <= cnt_inc;
      acc_sat_q <= acc_sat_q | sat_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_ACCUM;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCUM: if (load) state_d = ST_HOLD;
      ST_HOLD: begin
        if (load)           state_d = ST_HOLD;
        else if (out_ready) state_d = ST_ACCUM;
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  stream_result_reg #(.SW(SW)) u_result (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .ld_sum    (ld_sum),
    .ld_cnt    (ld_cnt),
    .ld_sat    (ld_sat),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cnt   (out_cnt),
    .out_sat   (out_sat),
    .out_valid (out_valid)
  );

endmodule

// File: tb/tb_stream_group_accum.sv
// tb/tb_stream_group_accum.sv - scoreboard bench for stream_group_accum (three configurations)
// Exercises flush when STREAM_GROUP_ACCUM_FLUSH_EN is defined.
module tb_stream_group_accum;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [5:0] in_data;
  logic       in_valid;
  logic       out_ready;
  logic       flush;
  logic       flush_eff;

  logic        in_ready_a, out_valid_a, out_sat_a;
  logic [15:0] out_sum_a;
  logic [7:0]  out_cnt_a;
  logic        in_ready_b, out_valid_b, out_sat_b;
  logic [7:0]  out_sum_b;
  logic [7:0]  out_cnt_b;
  logic        in_ready_c, out_valid_c, out_sat_c;
  logic [15:0] out_sum_c;
  logic [7:0]  out_cnt_c;

`ifdef STREAM_GROUP_ACCUM_FLUSH_EN
  assign flush_eff = flush;
`else
  assign flush_eff = 1'b0;
`endif

  stream_group_accum #(.DW(6), .SW(16), .GROUP(4)) u_a (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_a),
    .out_sum(out_sum_a), .out_cnt(out_cnt_a), .out_sat(out_sat_a), .out_valid(out_valid_a),
    .out_ready(out_ready)
`ifdef STREAM_GROUP_ACCUM_FLUSH_EN
    , .flush(flush)
`endif
  );

  stream_group_accum #(.DW(6), .SW(8), .GROUP(5)) u_b (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_b),
    .out_sum(out_sum_b), .out_cnt(out_cnt_b), .out_sat(out_sat_b), .out_valid(out_valid_b),
    .out_ready(out_ready)
`ifdef STREAM_GROUP_ACCUM_FLUSH_EN
    , .flush(flush)
`endif
  );

  stream_group_accum #(.DW(6), .SW(16), .GROUP(1)) u_c (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_c),
    .out_sum(out_sum_c), .out_cnt(out_cnt_c), .out_sat(out_sat_c), .out_valid(out_valid_c),
    .out_ready(out_ready)
`ifdef STREAM_GROUP_ACCUM_FLUSH_EN
    , .flush(flush)
`endif
  );

  typedef struct {
    longint sum;
    int     cnt;
    bit     sat;
  } res_t;

  res_t   exp_q[3][$];
  longint msum[3];
  int     mcnt[3];
  int     grp[3] = '{4, 5, 1};
  int     swd[3] = '{16, 8, 16};
  int     errors = 0;
  int     checks = 0;

  // Reference: a group is a list of accepted items; its result is the true sum clamped to 2^SW-1.
  task automatic observe(input int k, input logic ir, input logic ov, input logic [15:0] osum,
                         input logic [7:0] ocnt, input logic osat);
    bit     hold, exp_ir;
    res_t   e;
    longint mx;
    hold = (exp_q[k].size() != 0);
    checks++;
    if (hold) begin
      e = exp_q[k][0];
      if (ov !== 1'b1 || osum !== 16'(e.sum) || ocnt !== 8'(e.cnt) || osat !== e.sat) begin
        errors++;
        $display("FAIL beat[%0d] got v=%0b sum=%0d cnt=%0d sat=%0b, expected v=1 sum=%0d cnt=%0d sat=%0b",
                 k, ov, osum, ocnt, osat, e.sum, e.cnt, e.sat);
      end
    end else if (ov !== 1'b0) begin
      errors++;
      $display("FAIL idle[%0d] got out_valid=%0b, expected 0", k, ov);
    end
    exp_ir = !hold || out_ready;
    checks++;
    if (ir !== exp_ir) begin
      errors++;
      $display("FAIL in_ready[%0d] got %0b, expected %0b", k, ir, exp_ir);
    end
    if (hold && out_ready) void'(exp_q[k].pop_front());
    if (in_valid && exp_ir) begin
      msum[k] += longint'(in_data);
      mcnt[k]++;
    end
    if (mcnt[k] == grp[k] || (flush_eff && !hold && mcnt[k] > 0)) begin
      mx    = (64'sd1 <<< swd[k]) - 1;
      e.sum = (msum[k] > mx) ? mx : msum[k];
      e.cnt = mcnt[k];
      e.sat = (msum[k] > mx);
      exp_q[k].push_back(e);
      msum[k] = 0;
      mcnt[k] = 0;
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      observe(0, in_ready_a, out_valid_a, out_sum_a, out_cnt_a, out_sat_a);
      observe(1, in_ready_b, out_valid_b, 16'(out_sum_b), out_cnt_b, out_sat_b);
      observe(2, in_ready_c, out_valid_c, out_sum_c, out_cnt_c, out_sat_c);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    flush    = 1'b0;
    rst      = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_q[k].delete();
      msum[k] = 0;
      mcnt[k] = 0;
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send(input logic [5:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    flush     = 1'b0;
    do_reset();
    chk("reset_valid_a", 32'(out_valid_a), 0);
    chk("reset_sum_a", 32'(out_sum_a), 0);
    chk("reset_cnt_a", 32'(out_cnt_a), 0);

    send(2); send(4); send(6); send(8);
    in_valid = 1'b0;
    chk("t1_valid", 32'(out_valid_a), 1);
    chk("t1_sum", 32'(out_sum_a), 20);
    chk("t1_cnt", 32'(out_cnt_a), 4);
    chk("t1_sat", 32'(out_sat_a), 0);
    chk("t1_in_ready", 32'(in_ready_a), 1);

    do_reset();
    repeat (5) send(63);
    in_valid = 1'b0;
    chk("t2_sat_sum", 32'(out_sum_b), 255);
    chk("t2_sat_flag", 32'(out_sat_b), 1);
    chk("t2_sat_cnt", 32'(out_cnt_b), 5);
    repeat (5) send(1);
    in_valid = 1'b0;
    chk("t2_sum", 32'(out_sum_b), 5);
    chk("t2_flag", 32'(out_sat_b), 0);

    do_reset();
    out_ready = 1'b0;
    repeat (4) send(1);
    in_valid = 1'b0;
    chk("t3_valid", 32'(out_valid_a), 1);
    for (int i = 0; i < 10; i++) begin
      chk("t3_in_ready", 32'(in_ready_a), 0);
      chk("t3_stable", 32'(out_sum_a), 4);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("t3_consumed", 32'(out_valid_a), 0);
    repeat (4) send(2);
    in_valid = 1'b0;
    chk("t3_next_sum", 32'(out_sum_a), 8);

    do_reset();
    for (int i = 1; i <= 8; i++) begin
      send(6'(i));
      chk("t4_valid", 32'(out_valid_c), 1);
      chk("t4_sum", 32'(out_sum_c), 32'(i));
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("t4_drained", 32'(out_valid_c), 0);

    do_reset();
    send(3); send(5);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_async_valid_c", 32'(out_valid_c), 0);
    chk("t5_async_sum_c", 32'(out_sum_c), 0);
    do_reset();
    repeat (4) send(1);
    in_valid = 1'b0;
    chk("t5_sum", 32'(out_sum_a), 4);
    chk("t5_cnt", 32'(out_cnt_a), 4);

`ifdef STREAM_GROUP_ACCUM_FLUSH_EN
    do_reset();
    send(7); send(9);
    in_valid = 1'b0;
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    chk("t6_valid", 32'(out_valid_a), 1);
    chk("t6_sum", 32'(out_sum_a), 16);
    chk("t6_cnt", 32'(out_cnt_a), 2);
    repeat (3) @(posedge clk);
    #1 flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("t6_empty_flush", 32'(out_valid_a), 0);
    end
    flush = 1'b0;
`endif

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 6'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 7) == 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stream_group_accum.md
Name: stream_group_accum

Overview:
Downstream consumer of the custom_logic valid/ready output stream. Sums each group of GROUP accepted items into one result beat. Result beat carries the saturating sum, the item count and a saturation flag. Single-entry result register with a 2-state FSM; full-throughput when the sink is always ready.

Parameters:
DW, 6, input data width; matches the producer's DW.
SW, 16, sum width; SW >= DW required.
GROUP, 4, items per group; legal range 1..255.

Ports:
clk  input  1  clock; all logic on posedge
rst  input  1  asynchronous reset, active-high
in_data  input  DW  item from upstream down_data
in_valid  input  1  upstream down_valid
in_ready  output  1  to upstream down_ready
out_sum  output  SW  group sum, saturated at 2^SW-1
out_cnt  output  8  items in this result (GROUP, or fewer on flush)
out_sat  output  1  1 if any addition in the group saturated
out_valid  output  1  result valid
out_ready  input  1  sink ready

Behaviour:
- Reset (async assert, sync release). acc, cnt, out_sum, out_cnt and out_sat are 0. out_valid is 0. State is ACCUM. A partial group in progress at reset is discarded.
- Handshakes:
  - accept_in = in_valid & in_ready.
  - accept_out = out_valid & out_ready.
  - out_* held stable while out_valid & ~out_ready.
- Ready:
  - in_ready = 1 in ACCUM.
  - in_ready = out_ready in HOLD (combinational path out_ready->in_ready is permitted).
  - in_ready does not depend on in_valid.
- Arithmetic:
  - nxt = acc + zero-extended in_data, computed at SW+1 bits.
  - If the carry is set: acc_n = all-ones and sat_n = 1.
  - cnt is 8 bits.
- On accept_in:
  - If cnt+1 == GROUP: load out_sum = acc_n, out_cnt = cnt+1, out_sat = sat_n | acc_sat. Clear acc, cnt and acc_sat. out_valid <= 1. State goes to HOLD.
  - Else: acc <= acc_n, cnt <= cnt+1, acc_sat |= sat_n.
- HOLD:
  - accept_out with no group completing: out_valid <= 0, state goes to ACCUM.
  - accept_out in the same cycle as a group completing: the new result overwrites and out_valid stays 1 (GROUP=1 streams 1 result/cycle). An accept_in that does not complete the group accumulates normally.
- Latency: result visible the cycle after the completing item is accepted.
- Boundaries:
  - cnt never exceeds GROUP-1 between results.
  - acc saturates and never wraps.
  - No result is dropped; in_ready=0 prevents overwrite while the result is unconsumed.

Optional Feature:
STREAM_GROUP_ACCUM_FLUSH_EN.
- Defined:
  - Adds input port flush (1 bit, level, sampled on posedge).
  - In ACCUM, flush=1 with cnt>0 or accept_in closes the group: it emits the accumulated items including any item accepted that cycle, with out_cnt = actual count.
  - flush with an empty group and no accept_in is ignored.
  - In HOLD, flush is held off until ACCUM; the upstream keeps it asserted.
- Undefined: no flush port; groups close only at GROUP items.

Decomposition:
- Shared package stream_pkg:
  - FSM enum (ST_ACCUM, ST_HOLD).
  - CNT_W = 8.
  - Function sat_add(a, b) returning {sat, sum}.
- One natural sub-module: stream_result_reg, the single-entry valid/ready holding register for {out_sum, out_cnt, out_sat} with the overwrite-on-simultaneous rule.

Test Plan:
1. DW=6, GROUP=4, out_ready=1. Inputs 2,4,6,8 back-to-back -> one beat the next cycle: out_sum=20, out_cnt=4, out_sat=0. in_ready stays 1.
2. SW=8, GROUP=5. Input 63 x5 -> out_sum=255, out_sat=1. The following group 1,1,1,1,1 -> out_sum=5, out_sat=0.
3. Backpressure: out_ready=0 after a result -> in_ready=0 and out_sum stable for 10 cycles. Release out_ready -> beat consumed, then the next group accepted.
4. GROUP=1, in_valid and out_ready continuously high, inputs 1..8 -> 8 consecutive beats, out_sum=1..8, no bubbles.
5. Reset asserted mid-group after inputs 3,5 -> outputs 0 immediately. Then 1,1,1,1 -> out_sum=4 (partial group discarded).
6. FLUSH_EN: inputs 7,9 then flush=1 -> out_sum=16, out_cnt=2. Flush with an empty group -> no beat.
